pmul_accum: RTL and testbench

PMUL_ACCUM -- requirements
Module: pmul_accum

---
 rtl/pmul_accum.sv | 121 ++++++++++++
 tb/tb_pmul_accum.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pmul_accum.sv
// Bit-serial 4x4 polynomial multiplier: A is latched on start, D arrives one bit-slice per cycle.
// Optional macro PMUL_NEGACYCLIC_EN folds the product modulo x^4+1 (two's complement outputs).
module pmul_accum #(
  parameter int unsigned N = 4,
  localparam int unsigned CW = 2 * N + 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [N-1:0]  a0,
  input  logic [N-1:0]  a1,
  input  logic [N-1:0]  a2,
  input  logic [N-1:0]  a3,
  input  logic [3:0]    dcoeff,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] c0,
  output logic [CW-1:0] c1,
  output logic [CW-1:0] c2,
  output logic [CW-1:0] c3,
  output logic [CW-1:0] c4,
  output logic [CW-1:0] c5,
  output logic [CW-1:0] c6
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [1:0] JLast = 2'(N - 1);

  state_e        r_state, w_state_nxt;
  logic [1:0]    r_j, w_j_nxt;
  logic [N-1:0]  r_a [4];
  logic [N-1:0]  w_a_nxt [4];
  logic [CW-1:0] r_acc [7];
  logic [CW-1:0] w_acc_nxt [7];
  logic [CW-1:0] w_pp [7];
  logic          w_load;

  // Partial product of the current bit-slice: one adder tree per output degree.
  always_comb begin
    for (int m = 0; m < 7; m++) w_pp[m] = '0;
    for (int i = 0; i < 4; i++) begin
      for (int l = 0; l < 4; l++) begin
        if (dcoeff[l]) w_pp[i+l] = w_pp[i+l] + CW'(r_a[i]);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_j_nxt     = r_j;
    w_a_nxt     = r_a;
    w_acc_nxt   = r_acc;
    w_load      = 1'b0;
    case (r_state)
      StIdle: w_load = start;
      StRun: begin
        for (int m = 0; m < 7; m++) w_acc_nxt[m] = r_acc[m] + (w_pp[m] << r_j);
        w_j_nxt = r_j + 2'd1;
        if (r_j == JLast) begin
          w_state_nxt = StDone;
          w_j_nxt     = '0;
        end
      end
      StDone: begin
        if (out_ready) begin
          if (start) w_load = 1'b1;
          else       w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
    // A start accepted in IDLE or on the DONE handshake restarts the datapath.
    if (w_load) begin
      w_a_nxt[0]  = a0;
      w_a_nxt[1]  = a1;
      w_a_nxt[2]  = a2;
      w_a_nxt[3]  = a3;
      for (int m = 0; m < 7; m++) w_acc_nxt[m] = '0;
      w_j_nxt     = '0;
      w_state_nxt = StRun;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_j     <= '0;
      for (int i = 0; i < 4; i++) r_a[i] <= '0;
      for (int m = 0; m < 7; m++) r_acc[m] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_j     <= w_j_nxt;
      r_a     <= w_a_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  assign busy      = (r_state != StIdle);
  assign out_valid = (r_state == StDone);

`ifdef PMUL_NEGACYCLIC_EN
  assign c0 = r_acc[0] - r_acc[4];
  assign c1 = r_acc[1] - r_acc[5];
  assign c2 = r_acc[2] - r_acc[6];
  assign c3 = r_acc[3];
  assign c4 = '0;
  assign c5 = '0;
  assign c6 = '0;
`else
  assign c0 = r_acc[0];
  assign c1 = r_acc[1];
  assign c2 = r_acc[2];
  assign c3 = r_acc[3];
  assign c4 = r_acc[4];
  assign c5 = r_acc[5];
  assign c6 = r_acc[6];
`endif

endmodule

// File: tb/tb_pmul_accum.sv
// Randomised self-checking bench for pmul_accum against a whole-polynomial product model.
module tb_pmul_accum;

  localparam int N  = 4;
  localparam int CW = 2 * N + 3;

  logic          clk = 1'b0;
  logic          reset, start, out_ready;
  logic [N-1:0]  a0, a1, a2, a3;
  logic [3:0]    dcoeff;
  logic          busy, out_valid;
  logic [CW-1:0] c [7];

  int n_checks = 0;
  int n_errors = 0;

  logic [4*N-1:0]  cur_a;
  logic [7*CW-1:0] exp_c;

  pmul_accum #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a0        (a0),
    .a1        (a1),
    .a2        (a2),
    .a3        (a3),
    .dcoeff    (dcoeff),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c0        (c[0]),
    .c1        (c[1]),
    .c2        (c[2]),
    .c3        (c[3]),
    .c4        (c[4]),
    .c5        (c[5]),
    .c6        (c[6])
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [4*N-1:0] pack4(input int x0, input int x1, input int x2, input int x3);
    return {N'(x3), N'(x2), N'(x1), N'(x0)};
  endfunction

  // Reference: full schoolbook product of the two coefficient vectors.
  function automatic logic [7*CW-1:0] model(input logic [4*N-1:0] a, input logic [4*N-1:0] d);
    int acc [7];
    int r [7];
    logic [7*CW-1:0] p;
    for (int m = 0; m < 7; m++) acc[m] = 0;
    for (int i = 0; i < 4; i++)
      for (int l = 0; l < 4; l++)
        acc[i+l] += int'(a[i*N +: N]) * int'(d[l*N +: N]);
`ifdef PMUL_NEGACYCLIC_EN
    for (int m = 0; m < 3; m++) r[m] = acc[m] - acc[m+4];
    r[3] = acc[3];
    r[4] = 0;
    r[5] = 0;
    r[6] = 0;
`else
    r = acc;
`endif
    p = '0;
    for (int m = 0; m < 7; m++) p[m*CW +: CW] = CW'(r[m]);
    return p;
  endfunction

  function automatic logic [3:0] col(input logic [4*N-1:0] d, input int k);
    logic [3:0] v;
    for (int l = 0; l < 4; l++) v[l] = d[l*N + k];
    return v;
  endfunction

  task automatic rand_a();
    {a3, a2, a1, a0} = (4*N)'($urandom);
  endtask

  task automatic check_outputs(input string tag);
    for (int m = 0; m < 7; m++)
      check_eq($sformatf("%s c%0d", tag, m), 32'(c[m]), 32'(exp_c[m*CW +: CW]));
  endtask

  task automatic do_start(input logic [4*N-1:0] a);
    cur_a = a;
    {a3, a2, a1, a0} = a;
    start  = 1'b1;
    dcoeff = 4'($urandom);
  endtask

  // Expects start already driven; the next edge is the start edge.
  task automatic do_body(input logic [4*N-1:0] d, input string tag);
    exp_c = model(cur_a, d);
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) begin
      check_eq({tag, " run busy"}, 32'(busy), 32'd1);
      check_eq({tag, " run valid"}, 32'(out_valid), 32'd0);
      dcoeff    = col(d, k);
      start     = 1'($urandom);
      out_ready = 1'($urandom);
      rand_a();
      @(posedge clk); #1;
    end
    start     = 1'b0;
    out_ready = 1'b0;
    check_eq({tag, " done valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, " done busy"}, 32'(busy), 32'd1);
    check_outputs(tag);
  endtask

  task automatic do_handshake(input int delay, input bit chain, input logic [4*N-1:0] a_nx,
                              input string tag);
    for (int q = 0; q < delay; q++) begin
      out_ready = 1'b0;
      start     = (q == 1) ? 1'b1 : 1'($urandom);
      dcoeff    = 4'($urandom);
      rand_a();
      @(posedge clk); #1;
      check_eq({tag, " hold valid"}, 32'(out_valid), 32'd1);
      check_eq({tag, " hold busy"}, 32'(busy), 32'd1);
      check_outputs({tag, " hold"});
    end
    out_ready = 1'b1;
    start     = 1'b0;
    dcoeff    = 4'($urandom);
    if (chain) begin
      do_start(a_nx);
    end else begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_eq({tag, " ack valid"}, 32'(out_valid), 32'd0);
      check_eq({tag, " ack busy"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    logic [4*N-1:0] ra, rd, rn;
    bit pending;
    bit chain;

    reset = 1'b1; start = 1'b1; out_ready = 1'b1; dcoeff = 4'hF;
    {a3, a2, a1, a0} = '1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset busy", 32'(busy), 32'd0);
    check_eq("reset valid", 32'(out_valid), 32'd0);
    exp_c = '0;
    check_outputs("reset");
    reset = 1'b0; start = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    check_eq("idle busy", 32'(busy), 32'd0);

    do_start(pack4(1, 0, 0, 0));
    do_body(pack4(3, 5, 7, 9), "ident");
    do_handshake(0, 1'b0, '0, "ident");

    do_start(pack4(15, 15, 15, 15));
    do_body(pack4(15, 15, 15, 15), "max");
    do_handshake(3, 1'b0, '0, "max");

    // Abort after two sampled bits.
    rd = (4*N)'($urandom);
    do_start((4*N)'($urandom));
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      dcoeff = col(rd, k);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("abort valid", 32'(out_valid), 32'd0);
    check_eq("abort busy", 32'(busy), 32'd0);
    exp_c = '0;
    check_outputs("abort");
    do_start(pack4(2, 0, 0, 0));
    do_body(pack4(1, 1, 1, 1), "post");
    do_handshake(0, 1'b0, '0, "post");

    do_start((4*N)'($urandom));
    do_body((4*N)'($urandom), "b2b1");
    do_handshake(1, 1'b1, (4*N)'($urandom), "b2b1");
    do_body((4*N)'($urandom), "b2b2");
    do_handshake(0, 1'b0, '0, "b2b2");

    pending = 1'b0;
    for (int it = 0; it < 30; it++) begin
      ra = (4*N)'($urandom);
      rd = (4*N)'($urandom);
      rn = (4*N)'($urandom);
      if (!pending) do_start(ra);
      do_body(rd, $sformatf("rnd%0d", it));
      chain = 1'($urandom) && (it < 29);
      do_handshake(int'($urandom_range(0, 3)), chain, rn, $sformatf("rnd%0d", it));
      pending = chain;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
